// File: rtl/spi_mem_pkg.sv
// Shared constants for the serial SRAM protocol: command codes, field widths, FSM states.
package spi_mem_pkg;

    localparam int unsigned CMD_W          = 8;
    localparam int unsigned ADDR_W_DEFAULT = 24;

    localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [CMD_W-1:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCmd    = 3'd1,
        StAddr   = 3'd2,
        StWrite  = 3'd3,
        StRead   = 3'd4,
        StIgnore = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detection
// on the last two synchronised samples.
module spi_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    // Value the chain holds in reset; a high reset value suppresses a spurious
    // rising edge when the input is already high as reset is released.
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    // Shift the raw input through the chain and remember the previous synced sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= (chain_q << 1) | SYNC_STAGES'(din);
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_sram_responder.sv
// SPI mode-0 target for the serial SRAM protocol, backed by an internal byte array.
// All SPI inputs are oversampled in the clk domain.
module spi_sram_responder
    import spi_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEFAULT,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sram_ce,
    input  logic sck,
    input  logic sram_si,
    output logic sram_so,
    output logic busy,
    output logic cmd_err,
    output logic wr_pulse
);

    localparam int unsigned DEPTH = 1 << MEM_AW;
    // Counter must reach both the last command bit and the last address bit.
    localparam int unsigned CNT_W = ($clog2(ADDR_W) > 3) ? $clog2(ADDR_W) : 3;

    logic ce_rise, ce_fall, ce_level_unused;
    logic sck_rise, sck_fall, sck_level_unused;
    logic si_s, si_rise_unused, si_fall_unused;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ce (
        .clk   (clk),
        .reset (reset),
        .din   (sram_ce),
        .sync  (ce_level_unused),
        .rise  (ce_rise),
        .fall  (ce_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .sync  (sck_level_unused),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_si (
        .clk   (clk),
        .reset (reset),
        .din   (sram_si),
        .sync  (si_s),
        .rise  (si_rise_unused),
        .fall  (si_fall_unused)
    );

    spi_state_e         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]         byte_q, byte_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic               is_write_q, is_write_d;
    logic               so_q, so_d;
    logic               cmd_err_q, cmd_err_d;
    logic               wr_pulse_q, wr_pulse_d;

    logic [7:0]         mem [DEPTH];
    logic [7:0]         rd_data_q;
    logic               mem_we, mem_re;
    logic [MEM_AW-1:0]  mem_addr;
    logic [7:0]         mem_wdata;

    // Protocol state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            addr_q     <= '0;
            is_write_q <= 1'b0;
            so_q       <= 1'b0;
            cmd_err_q  <= 1'b0;
            wr_pulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            addr_q     <= addr_d;
            is_write_q <= is_write_d;
            so_q       <= so_d;
            cmd_err_q  <= cmd_err_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Next-state decode, shift registers and memory strobes.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        addr_d     = addr_q;
        is_write_d = is_write_q;
        so_d       = so_q;
        cmd_err_d  = 1'b0;
        wr_pulse_d = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = byte_q;

        // Deselect overrides any sck edge seen in the same cycle; partial data is dropped.
        if (state_q != StIdle && ce_fall) begin
            state_d   = StIdle;
            so_d      = 1'b0;
            bit_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    so_d = 1'b0;
                    if (ce_rise) begin
                        state_d   = StCmd;
                        bit_cnt_d = '0;
                    end
                end
                StCmd: begin
                    if (sck_rise) begin
                        byte_d = {byte_q[6:0], si_s};
                        if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                            bit_cnt_d = '0;
                            if (byte_d == CMD_WRITE) begin
                                is_write_d = 1'b1;
                                state_d    = StAddr;
                            end else if (byte_d == CMD_READ) begin
                                is_write_d = 1'b0;
                                state_d    = StAddr;
                            end else begin
                                cmd_err_d = 1'b1;
                                state_d   = StIgnore;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StAddr: begin
                    // Only the low MEM_AW bits are kept; upper bits shift out and alias.
                    if (sck_rise) begin
                        addr_d = {addr_q[MEM_AW-2:0], si_s};
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            bit_cnt_d = '0;
                            mem_re    = 1'b1;
                            mem_addr  = addr_d;
                            state_d   = is_write_q ? StWrite : StRead;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StWrite: begin
                    if (sck_rise) begin
                        byte_d = {byte_q[6:0], si_s};
                        if (bit_cnt_q == CNT_W'(7)) begin
                            mem_we     = 1'b1;
                            mem_wdata  = byte_d;
                            wr_pulse_d = 1'b1;
                            addr_d     = addr_q + 1'b1;
                            bit_cnt_d  = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StRead: begin
                    // After the last bit of a byte, fetch the next one so the
                    // following fall can drive its MSB without a gap.
                    if (sck_fall) begin
                        so_d = rd_data_q[~bit_cnt_q[2:0]];
                        if (bit_cnt_q == CNT_W'(7)) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 1'b1;
                            mem_re    = 1'b1;
                            mem_addr  = addr_d;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                StIgnore: begin
                    so_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                    so_d    = 1'b0;
                end
            endcase
        end
    end

    // Single-port synchronous byte array; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        if (mem_re) begin
            rd_data_q <= mem[mem_addr];
        end
    end

    assign sram_so  = so_q;
    assign busy     = (state_q != StIdle);
    assign cmd_err  = cmd_err_q;
    assign wr_pulse = wr_pulse_q;

endmodule
